// File: rtl/lifo_arb_ctrl.sv
// Round-robin arbiter that shares one single-port LIFO stack among CLIENTS push/pop
// requesters. It tracks occupancy with a shadow count and inserts a turnaround bubble at full or empty.
module lifo_arb_ctrl #(
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 4,
  parameter int CLIENTS = 2
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [CLIENTS-1:0]        push_valid_i,
  input  logic [CLIENTS*DWIDTH-1:0] push_data_i,
  output logic [CLIENTS-1:0]        push_ready_o,
  input  logic [CLIENTS-1:0]        pop_req_i,
  output logic [CLIENTS-1:0]        pop_gnt_o,
  output logic [CLIENTS-1:0]        pop_valid_o,
  output logic [DWIDTH-1:0]         pop_data_o,
  output logic                      lifo_wrreq_o,
  output logic [DWIDTH-1:0]         lifo_data_o,
  output logic                      lifo_rdreq_o,
  input  logic [DWIDTH-1:0]         lifo_q_i,
  output logic [AWIDTH:0]           usedw_o
);

  // last_op  | meaning
  // OP_IDLE  | no grant last cycle, so no bubble applies
  // OP_WRITE | push granted last cycle, so a pop is blocked while full
  // OP_READ  | pop granted last cycle, so a push is blocked while empty

  localparam int CW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;
  localparam logic [AWIDTH:0] DEPTH   = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [CW:0]     NCL     = (CW+1)'(CLIENTS);
  localparam logic [CW-1:0]   LAST_CL = CW'(CLIENTS - 1);

  typedef enum logic [1:0] {OP_IDLE, OP_WRITE, OP_READ} op_e;

  op_e                last_op;
  logic [AWIDTH:0]    cnt;
  logic [CW-1:0]      rr_ptr;
  logic [CW-1:0]      win;
  logic [CW-1:0]      scan_idx;
  logic [CW:0]        scan_sum;
  logic               found;
  logic               win_pop;
  logic               push_ok;
  logic               pop_ok;
  logic               push_gnt;
  logic               pop_gnt;
  logic [CLIENTS-1:0] push_elig;
  logic [CLIENTS-1:0] pop_elig;
  logic [CLIENTS-1:0] pop_pipe;

  assign push_ok   = (cnt < DEPTH) && !(last_op == OP_READ && cnt == '0);
  assign pop_ok    = (cnt != '0) && !(last_op == OP_WRITE && cnt == DEPTH);
  assign push_elig = push_valid_i & {CLIENTS{push_ok}};
  assign pop_elig  = pop_req_i & {CLIENTS{pop_ok}};

  // The scan starts at rr_ptr and wraps. The first client with any eligible request wins.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_pop  = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      scan_sum = {1'b0, rr_ptr} + (CW+1)'(i);
      if (scan_sum >= NCL) scan_sum = scan_sum - NCL;
      scan_idx = scan_sum[CW-1:0];
      if (!found && (push_elig[scan_idx] || pop_elig[scan_idx])) begin
        found   = 1'b1;
        win     = scan_idx;
        win_pop = pop_elig[scan_idx];
      end
    end
  end

  always_comb begin
    push_ready_o = '0;
    pop_gnt_o    = '0;
    if (found && !srst_i) begin
      if (win_pop) pop_gnt_o[win] = 1'b1;
      else         push_ready_o[win] = 1'b1;
    end
  end

  assign push_gnt = |push_ready_o;
  assign pop_gnt  = |pop_gnt_o;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt          <= '0;
      last_op      <= OP_IDLE;
      rr_ptr       <= '0;
      lifo_wrreq_o <= 1'b0;
      lifo_rdreq_o <= 1'b0;
      lifo_data_o  <= '0;
      pop_pipe     <= '0;
      pop_valid_o  <= '0;
    end else begin
      lifo_wrreq_o <= push_gnt;
      lifo_rdreq_o <= pop_gnt;
      // The client id rides alongside the read, so it is aligned with q one cycle after rdreq.
      pop_pipe     <= pop_gnt_o;
      pop_valid_o  <= pop_pipe;
      if (push_gnt) begin
        lifo_data_o <= push_data_i[win*DWIDTH +: DWIDTH];
        cnt         <= cnt + (AWIDTH+1)'(1);
        last_op     <= OP_WRITE;
      end else if (pop_gnt) begin
        cnt         <= cnt - (AWIDTH+1)'(1);
        last_op     <= OP_READ;
      end else begin
        last_op     <= OP_IDLE;
      end
      if (found) rr_ptr <= (win == LAST_CL) ? '0 : win + CW'(1);
    end
  end

  assign usedw_o    = cnt;
  assign pop_data_o = (|pop_valid_o) ? lifo_q_i : '0;

endmodule

// File: tb/tb_lifo_arb_ctrl.sv
// Bench for lifo_arb_ctrl: a behavioural stack drives lifo_q_i, and a queue-based model
// predicts every grant, stack request and pop return each cycle.
module tb_lifo_arb_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NC = 2;
  localparam int DEPTH = 16;
  localparam int LAST_NONE = 0, LAST_PUSH = 1, LAST_POP = 2;

  logic              clk_i = 1'b0;
  logic              srst_i;
  logic [NC-1:0]     push_valid_i, push_ready_o, pop_req_i, pop_gnt_o, pop_valid_o;
  logic [NC*DW-1:0]  push_data_i;
  logic [DW-1:0]     pop_data_o, lifo_data_o;
  logic [DW-1:0]     lifo_q_i = '0;
  logic              lifo_wrreq_o, lifo_rdreq_o;
  logic [AW:0]       usedw_o;

  always #5 clk_i = ~clk_i;

  lifo_arb_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .CLIENTS(NC)) dut (
    .clk_i(clk_i), .srst_i(srst_i),
    .push_valid_i(push_valid_i), .push_data_i(push_data_i), .push_ready_o(push_ready_o),
    .pop_req_i(pop_req_i), .pop_gnt_o(pop_gnt_o), .pop_valid_o(pop_valid_o), .pop_data_o(pop_data_o),
    .lifo_wrreq_o(lifo_wrreq_o), .lifo_data_o(lifo_data_o), .lifo_rdreq_o(lifo_rdreq_o),
    .lifo_q_i(lifo_q_i), .usedw_o(usedw_o)
  );

  // Stack model: q is registered and appears one cycle after rdreq.
  logic [DW-1:0] stk_mem [0:63];
  int stk_sp = 0;
  always @(posedge clk_i) begin
    if (srst_i) stk_sp <= 0;
    else if (lifo_wrreq_o) begin
      stk_mem[stk_sp & 63] <= lifo_data_o;
      stk_sp <= stk_sp + 1;
    end else if (lifo_rdreq_o) begin
      lifo_q_i <= stk_mem[(stk_sp - 1) & 63];
      stk_sp <= stk_sp - 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int            m_cnt, m_last, m_rr;
  logic [DW-1:0] m_stk[$];
  bit            exp_wr, exp_rd;
  logic [DW-1:0] exp_wdata;
  int            r1_cl, r2_cl;
  logic [DW-1:0] r1_dat, r2_dat;
  logic [NC-1:0] g_push, g_pop;
  int            cyc = 0;

  // Values sampled from the DUT in the last step, for directed checks
  logic [NC-1:0] s_push, s_pop;
  logic          s_rdreq;
  logic [AW:0]   s_usedw;
  logic [DW-1:0] seen_data[$];
  int            seen_cyc[$];

  task automatic model_reset();
    m_cnt = 0; m_last = LAST_NONE; m_rr = 0; m_stk.delete();
    r1_cl = -1; r2_cl = -1; r1_dat = '0; r2_dat = '0;
    exp_wr = 0; exp_rd = 0; exp_wdata = '0;
  endtask

  task automatic step();
    int win, k;
    bit wpop, pe, we;
    logic [NC-1:0] ep, eq;
    #2;
    win = -1; wpop = 0; ep = '0; eq = '0;
    if (!srst_i) begin
      for (int i = 0; i < NC; i++) begin
        k  = (m_rr + i) % NC;
        pe = pop_req_i[k] && m_cnt > 0 && !(m_last == LAST_PUSH && m_cnt == DEPTH);
        we = push_valid_i[k] && m_cnt < DEPTH && !(m_last == LAST_POP && m_cnt == 0);
        if (win < 0 && (pe || we)) begin win = k; wpop = pe; end
      end
    end
    if (win >= 0) begin
      if (wpop) eq[win] = 1'b1;
      else      ep[win] = 1'b1;
    end
    check("push_ready", push_ready_o, ep);
    check("pop_gnt", pop_gnt_o, eq);
    check("usedw", usedw_o, m_cnt);
    check("wrreq", lifo_wrreq_o, exp_wr);
    check("rdreq", lifo_rdreq_o, exp_rd);
    if (exp_wr) check("wdata", lifo_data_o, exp_wdata);
    check("pop_valid", pop_valid_o, (r2_cl >= 0) ? (32'd1 << r2_cl) : 32'd0);
    if (r2_cl >= 0) check("pop_data", pop_data_o, r2_dat);
    s_push = push_ready_o; s_pop = pop_gnt_o; s_rdreq = lifo_rdreq_o; s_usedw = usedw_o;
    if (pop_valid_o != '0) begin
      seen_data.push_back(pop_data_o);
      seen_cyc.push_back(cyc);
    end
    g_push = ep; g_pop = eq;
    if (srst_i) model_reset();
    else begin
      r2_cl = r1_cl; r2_dat = r1_dat; r1_cl = -1;
      exp_wr = 0; exp_rd = 0;
      if (win >= 0) begin
        m_rr = (win + 1) % NC;
        if (wpop) begin
          r1_cl = win; r1_dat = m_stk.pop_back(); m_cnt--; m_last = LAST_POP; exp_rd = 1;
        end else begin
          exp_wdata = push_data_i[win*DW +: DW];
          m_stk.push_back(exp_wdata); m_cnt++; m_last = LAST_PUSH; exp_wr = 1;
        end
      end else m_last = LAST_NONE;
    end
    @(posedge clk_i); #1;
    cyc++;
  endtask

  task automatic reset_dut();
    srst_i = 1; push_valid_i = '0; pop_req_i = '0;
    step(); step();
    srst_i = 0;
  endtask

  task automatic push_one(input int c, input logic [DW-1:0] d);
    int n = 0;
    push_valid_i[c] = 1'b1;
    push_data_i[c*DW +: DW] = d;
    do begin step(); n++; end while (!g_push[c] && n < 50);
    push_valid_i[c] = 1'b0;
    check("push_wait", {31'd0, g_push[c]}, 32'd1);
  endtask

  task automatic pop_one(input int c);
    int n = 0;
    pop_req_i[c] = 1'b1;
    do begin step(); n++; end while (!g_pop[c] && n < 50);
    pop_req_i[c] = 1'b0;
    check("pop_wait", {31'd0, g_pop[c]}, 32'd1);
  endtask

  task automatic rand_drive(input int push_pct, input int pop_pct);
    for (int c = 0; c < NC; c++) begin
      if (!push_valid_i[c] || g_push[c]) begin
        push_valid_i[c] = ($urandom_range(99) < push_pct);
        push_data_i[c*DW +: DW] = DW'($urandom);
      end
      if (!pop_req_i[c] || g_pop[c]) pop_req_i[c] = ($urandom_range(99) < pop_pct);
    end
    srst_i = ($urandom_range(299) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ngr, npushed, n0, n1, alt_err, nrd, gcyc, n;
    int push_pct[6] = '{80, 20, 60, 95, 5, 50};
    int pop_pct[6]  = '{20, 80, 60, 10, 95, 50};
    srst_i = 1; push_valid_i = '0; pop_req_i = '0; push_data_i = '0;
    g_push = '0; g_pop = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    reset_dut();

    // Fill with client 0 until the stack is full, then keep a 17th push pending.
    npushed = 0; ngr = 0;
    push_valid_i[0] = 1'b1; push_data_i[DW-1:0] = 8'h01;
    for (int i = 0; i < 22; i++) begin
      step();
      if (s_push[0]) ngr++;
      if (g_push[0]) begin npushed++; push_data_i[DW-1:0] = DW'(npushed + 1); end
    end
    check("fill_grants", ngr, 16);
    check("fill_usedw", s_usedw, 16);
    check("fill_held", s_push, 0);
    push_valid_i = '0;

    // Last push at full while a pop is already requested: exactly one idle cycle.
    reset_dut();
    for (int i = 0; i < 15; i++) push_one(0, DW'(8'h40 + i));
    push_valid_i[1] = 1'b1; push_data_i[DW +: DW] = 8'h4F; pop_req_i[0] = 1'b1;
    step(); push_valid_i[1] = 1'b0;
    check("ta_push", s_push, 2'b10);
    step();
    check("ta_bubble", s_pop, 2'b00);
    step();
    check("ta_pop", s_pop, 2'b01);
    n = 0;
    while (m_cnt > 0 && n < 40) begin step(); n++; end
    pop_req_i[0] = 1'b0;
    push_valid_i[1] = 1'b1; push_data_i[DW +: DW] = 8'h77;
    step();
    check("mirror_bubble", s_push, 2'b00);
    step(); push_valid_i[1] = 1'b0;
    check("mirror_push", s_push, 2'b10);
    step();

    // LIFO order with back-to-back pops.
    reset_dut();
    push_one(0, 8'hA1); push_one(0, 8'hA2); push_one(0, 8'hA3);
    seen_data.delete(); seen_cyc.delete(); gcyc = -1;
    pop_req_i[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (s_pop == 2'b01 && gcyc < 0) gcyc = cyc - 1;
    end
    pop_req_i[0] = 1'b0;
    repeat (4) step();
    check("lifo_n", seen_data.size(), 3);
    if (seen_data.size() == 3) begin
      check("lifo_0", seen_data[0], 8'hA3);
      check("lifo_1", seen_data[1], 8'hA2);
      check("lifo_2", seen_data[2], 8'hA1);
      check("lifo_lat", seen_cyc[0] - gcyc, 2);
      check("lifo_b2b", seen_cyc[2] - seen_cyc[0], 2);
    end
    check("lifo_usedw", s_usedw, 0);

    // Round robin between two always-valid pushers, then pop priority within a client.
    reset_dut();
    push_valid_i = 2'b11; push_data_i = 16'h1122;
    n0 = 0; n1 = 0; alt_err = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (s_push == 2'b01) n0++;
      else if (s_push == 2'b10) n1++;
      if (s_push != ((i % 2 == 0) ? 2'b01 : 2'b10)) alt_err++;
      for (int c = 0; c < NC; c++) if (g_push[c]) push_data_i[c*DW +: DW] = DW'($urandom);
    end
    push_valid_i = '0;
    check("rr_n0", n0, 4);
    check("rr_n1", n1, 4);
    check("rr_alt", alt_err, 0);
    push_valid_i[0] = 1'b1; pop_req_i[0] = 1'b1;
    step(); pop_req_i[0] = 1'b0;
    check("prio_pop", s_pop, 2'b01);
    check("prio_push_held", s_push, 2'b00);
    step(); push_valid_i[0] = 1'b0;
    check("prio_push_next", s_push, 2'b01);
    repeat (3) step();

    // Empty guard.
    reset_dut();
    pop_req_i[0] = 1'b1; ngr = 0; nrd = 0;
    repeat (5) begin
      step();
      if (s_pop != '0) ngr++;
      if (s_rdreq) nrd++;
    end
    pop_req_i[0] = 1'b0;
    check("empty_gnt", ngr, 0);
    check("empty_rdreq", nrd, 0);

    // Reset in the cycle after a pop grant discards the return.
    reset_dut();
    push_one(0, 8'h33);
    pop_req_i[0] = 1'b1;
    step(); pop_req_i[0] = 1'b0;
    check("rmp_gnt", s_pop, 2'b01);
    seen_data.delete(); seen_cyc.delete();
    srst_i = 1; step(); srst_i = 0;
    step();
    check("rmp_usedw", s_usedw, 0);
    repeat (3) step();
    check("rmp_no_valid", seen_data.size(), 0);
    push_one(0, 8'h5C); pop_one(0);
    repeat (3) step();
    check("rmp_n", seen_data.size(), 1);
    if (seen_data.size() == 1) check("rmp_data", seen_data[0], 8'h5C);

    // Randomised phases biased towards full, empty and mixed traffic.
    reset_dut();
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 500; i++) begin
        rand_drive(push_pct[ph], pop_pct[ph]);
        step();
      end
    end
    srst_i = 0; push_valid_i = '0; pop_req_i = '0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lifo_arb_ctrl.md
Name: lifo_arb_ctrl

Overview:
- Shares one single-port LIFO stack instance (wrreq/rdreq/q/empty/full/usedw) among CLIENTS requesters.
- Each client can push (valid/ready) and pop (request/grant, with a data return).
- Issues at most one LIFO operation per cycle, chosen round-robin, and never overflows or underflows the stack.
- Inserts a turnaround bubble when the operation type changes at full or empty, where the stack's pointers must not see back-to-back opposite operations.

Parameters:
- DWIDTH, 8, data width of stack entries.
- AWIDTH, 4, stack address width; DEPTH = 2**AWIDTH.
- CLIENTS, 2, number of requesters (1..8).

Ports:
- clk_i  in  1  clock.
- srst_i  in  1  synchronous active-high reset. Also drives the stack instance's reset.
- push_valid_i  in  CLIENTS  per-client push request.
- push_data_i  in  CLIENTS*DWIDTH  per-client push data; client k uses bits [k*DWIDTH +: DWIDTH].
- push_ready_o  out  CLIENTS  one-hot push acceptance; combinational.
- pop_req_i  in  CLIENTS  per-client pop request, held until granted.
- pop_gnt_o  out  CLIENTS  one-hot pop grant; combinational.
- pop_valid_o  out  CLIENTS  one-hot pop data return.
- pop_data_o  out  DWIDTH  popped data, qualified by pop_valid_o.
- lifo_wrreq_o  out  1  stack write request; registered.
- lifo_data_o  out  DWIDTH  stack write data; registered.
- lifo_rdreq_o  out  1  stack read request; registered.
- lifo_q_i  in  DWIDTH  stack read data, valid 1 cycle after rdreq.
- usedw_o  out  AWIDTH+1  shadow occupancy, 0..DEPTH.

Behaviour:
- Reset values: push_ready_o=0, pop_gnt_o=0, pop_valid_o=0, pop_data_o=0, lifo_wrreq_o=0, lifo_rdreq_o=0, lifo_data_o=0, usedw_o=0, rr_ptr=0, last_op=IDLE.
- Shadow count cnt:
  - Increments at the clock edge ending a push grant.
  - Decrements at the clock edge ending a pop grant.
  - Never changes by more than 1 per cycle.
  - The stack's own flags are not used; they lag the registered requests.
- Eligibility per client k:
  - Push eligible: push_valid_i[k] && cnt<DEPTH && !(last_op==READ && cnt==0).
  - Pop eligible: pop_req_i[k] && cnt>0 && !(last_op==WRITE && cnt==DEPTH).
  - The last two terms in each line are the turnaround bubble.
- Arbitration:
  - Scan clients starting at rr_ptr; the first client with any eligible request wins.
  - Within the winning client, pop has priority over push.
  - Exactly one of push_ready_o / pop_gnt_o bits is high for the winner; all others are 0.
  - After any grant, rr_ptr = winner+1 mod CLIENTS. With no grant, rr_ptr holds.
- last_op register: WRITE/READ/IDLE, records the operation granted in the previous cycle. An idle cycle sets IDLE and clears the bubble.
- Timing for a grant in cycle t:
  - Push: lifo_wrreq_o=1 and lifo_data_o=push data in cycle t+1.
  - Pop: lifo_rdreq_o=1 in cycle t+1, the stack presents q in cycle t+2, and pop_valid_o[k]=1 with pop_data_o=lifo_q_i in cycle t+2.
  - Total pop latency is 2 cycles from grant.
  - The client id travels through a 2-stage one-hot pipeline.
  - lifo_wrreq_o and lifo_rdreq_o are never both 1.
- Back-to-back pops (by the same or different clients) are supported at one per cycle. Returns are in grant order.
- Push data is accepted only on push_valid_i && push_ready_o. A client must hold push_data_i stable while valid.
- Reset mid-operation: the next cycle has all outputs at reset values, in-flight pop returns are discarded (no pop_valid_o), and cnt=0. The stack is reset in the same cycle.
- usedw_o = cnt, registered.

Test Plan:
- Fill: client0 pushes 0x01..0x10 continuously with DEPTH=16 → 16 grants, usedw_o=16. The 17th push is held with push_ready_o=0 for all following cycles.
- LIFO order: push 0xA1,0xA2,0xA3, then pop x3 back-to-back → pop_data_o = 0xA3, 0xA2, 0xA1 on 3 consecutive cycles, first return 2 cycles after the first pop_gnt_o; usedw_o returns to 0.
- Round-robin: CLIENTS=2, both push_valid_i held high for 8 cycles → grants alternate 0,1,0,1…, 4 each. Pop has priority when a client asserts push and pop together.
- Turnaround: fill to 16 with the last push in cycle t, pop requested from cycle t → no grant in t+1, pop_gnt_o in t+2. The mirror case at cnt=0 (pop, then push) also gets a 1-cycle bubble.
- Empty guard: cnt=0 and pop_req_i=1 for 5 cycles → pop_gnt_o stays 0, no lifo_rdreq_o.
- Reset mid-pop: assert srst_i in the cycle after pop_gnt_o → no pop_valid_o, usedw_o=0 next cycle, and a subsequent push/pop of 0x5C returns 0x5C.
